qdr_lvds_rx: RTL and testbench
==============================

Name: qdr_lvds_rx

Overview:
- Receive-side deframer for the 4-lane QDR LVDS ADC link driven by the existing transmitter (DA[3:0], DACLK, DAFRAME).
- Synchronises the link into the local clock and detects beats from DACLK transitions.
- Aligns to DAFRAME, reassembles 14-bit samples plus the overrange flag, and presents one valid-strobed word per frame to downstream capture logic.

Parameters:
- SYNC_STAGES, 2, flop stages on DA/DACLK/DAFRAME before use (min 2)
- LOCK_FRAMES, 2, consecutive well-formed frames required to enter LOCKED (1..15)
- TIMEOUT_CYC, 64, clk cycles without a DACLK transition before forcing HUNT

Ports:
- clk  in  1  local sampling clock, ≥2x the link beat rate
- reset  in  1  asynchronous, active-low reset
- DA  in  4  serial data lanes
- DACLK  in  1  link clock; every transition marks one beat
- DAFRAME  in  1  high during beat 0 of each frame
- data_out  out  14  last received sample
- ovr_out  out  1  overrange flag of last sample
- data_valid  out  1  one-cycle strobe, data_out/ovr_out updated
- locked  out  1  high in LOCKED state
- frame_err  out  1  one-cycle strobe on framing violation
- parity_err  out  1  one-cycle strobe on parity failure (0 without macro)

Behaviour:
- Reset (reset=0): all outputs 0, synchroniser flops 0, beat counter 0, state HUNT. Takes effect immediately, including mid-frame; any partial word is discarded.
- Frame format: 16-bit word W = {data[13:0], ovr, par}, where par is even parity over W[15:1]. Four beats per frame, MSB nibble first: beat k carries W[15-4k : 12-4k], with DA[3] the MSB of the nibble.
- Beat strobe: synchronised DACLK differs from its previous registered value. The nibble is taken from synchronised DA in the same cycle.
- HUNT: wait for a beat with DAFRAME=1. That beat is beat 0; load nibble, set beat_cnt=1, good_cnt=0, go to SYNC.
- SYNC: collect beats 1..3. The next beat after beat 3 must carry DAFRAME=1.
  - If DAFRAME=1: good_cnt++.
  - If good_cnt reaches LOCK_FRAMES: go to LOCKED.
  - No data_valid is emitted in SYNC.
- LOCKED: on completing beat 3, latch data_out=W[15:2] and ovr_out=W[1], and pulse data_valid. Latency: data_valid rises SYNC_STAGES+1 clk edges after the edge that first samples the 4th beat's DACLK transition.
- DAFRAME=1 on beat 1..3 (SYNC or LOCKED): pulse frame_err, discard partial word, treat this beat as beat 0, go to SYNC with good_cnt=0.
- DAFRAME=0 on expected beat 0: pulse frame_err, go to HUNT.
- No beat for TIMEOUT_CYC cycles in any non-HUNT state: go to HUNT without frame_err.
- locked drops in the same cycle the state leaves LOCKED.
- data_out and ovr_out hold between strobes and do not clear on leaving LOCKED.
- Simultaneous beat and timeout expiry: the beat wins and the timeout counter reloads.
- beat_cnt wraps 3→0. Timeout counter saturates.

Optional Feature:
- Macro: QDR_LVDS_RX_PARITY_CHECK_EN.
- Defined: recompute even parity over W[15:1] and compare with W[0]. On mismatch in LOCKED, pulse parity_err instead of data_valid; data_out/ovr_out are not updated and the state is unchanged.
- Undefined: par is ignored, parity_err is tied 0, and every LOCKED frame strobes data_valid.

Decomposition:
- Package qdr_lvds_pkg:
  - DATA_W=14, LANES=4, BEATS=4, WORD_W=16
  - rx_state_t enum {HUNT, SYNC, LOCKED}
  - function for W parity
  - Shared with the transmitter.
- Sub-module qdr_lvds_rx_sync: SYNC_STAGES-deep multi-bit synchroniser for {DA, DACLK, DAFRAME}, async active-low reset to 0.

Test Plan:
- Reset then 3 frames of sample 0x1FFF, ovr 0 (W=0x7FFD, nibbles 7,F,F,D) → locked rises after frame 2; frame 3 gives data_valid with data_out=0x1FFF, ovr_out=0.
- Locked link, sample 0x2000 ovr 1 (W=0x8002, nibbles 8,0,0,2) → data_out=0x2000, ovr_out=1, single-cycle data_valid at the specified latency.
- Locked link, DAFRAME asserted on beat 2 → frame_err pulse, locked=0, no data_valid for the partial word; relock after LOCK_FRAMES clean frames.
- Locked link, DACLK stops for 70 cycles → locked=0 by cycle 64, no frame_err; data_out holds the last value.
- Reset asserted mid-frame at beat 2 → all outputs 0 immediately; next clean frames relock normally.
- With QDR_LVDS_RX_PARITY_CHECK_EN, send W=0x7FFC (bad parity) → parity_err pulse, no data_valid, data_out unchanged, locked stays 1.

Source files
------------

// File: rtl/qdr_lvds_pkg.sv
// qdr_lvds_pkg: link geometry, receiver states and word parity shared by the QDR LVDS transmitter and receiver.
package qdr_lvds_pkg;
   localparam int DATA_W = 14;
   localparam int LANES  = 4;
   localparam int BEATS  = 4;
   localparam int WORD_W = 16;

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} rx_state_t;

   // Even parity bit over W[15:1]; caller passes those bits only.
   function automatic logic word_parity(input logic [WORD_W-2:0] w);
      return ^w;
   endfunction
endpackage

// File: rtl/qdr_lvds_rx_sync.sv
// qdr_lvds_rx_sync: STAGES-deep multi-bit synchroniser, async active-low reset to 0.
module qdr_lvds_rx_sync #(
   parameter int STAGES = 2,
   parameter int W      = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [STAGES-1:0][W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/qdr_lvds_rx.sv
// qdr_lvds_rx: 4-lane QDR LVDS deframer (HUNT/SYNC/LOCKED) emitting one strobed sample per frame.
// Define QDR_LVDS_RX_PARITY_CHECK_EN to drop bad-parity frames and flag them on parity_err.
module qdr_lvds_rx
   import qdr_lvds_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LANES-1:0]  DA,
   input  logic              DACLK,
   input  logic              DAFRAME,
   output logic [DATA_W-1:0] data_out,
   output logic              ovr_out,
   output logic              data_valid,
   output logic              locked,
   output logic              frame_err,
   output logic              parity_err
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int BW = $clog2(BEATS);

   logic [LANES+1:0]          s_q;
   logic                      clk_prev_q, beat_q, fr_q;
   logic [LANES-1:0]          nib_q;
   rx_state_t                 state_q, state_d;
   logic [BW-1:0]             cnt_q, cnt_d;
   logic [3:0]                good_q, good_d;
   logic [WORD_W-LANES-1:0]   word_q, word_d;
   logic [TW-1:0]             to_q, to_d;
   logic [DATA_W-1:0]         data_q, data_d;
   logic                      ovr_q, ovr_d, dv_q, dv_d, ferr_q, ferr_d, perr_q, perr_d;
   logic                      par_bad;

   qdr_lvds_rx_sync #(.STAGES(SYNC_STAGES), .W(LANES + 2)) u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d_i   ({DA, DACLK, DAFRAME}),
      .q_o   (s_q)
   );

`ifdef QDR_LVDS_RX_PARITY_CHECK_EN
   assign par_bad = word_parity({word_q, nib_q[LANES-1:1]}) != nib_q[0];
`else
   assign par_bad = 1'b0;
`endif

   // Beat detect is registered together with its nibble so the FSM sees a clean, aligned beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_prev_q <= 1'b0;
         beat_q     <= 1'b0;
         nib_q      <= '0;
         fr_q       <= 1'b0;
      end else begin
         clk_prev_q <= s_q[1];
         beat_q     <= s_q[1] ^ clk_prev_q;
         nib_q      <= s_q[LANES+1:2];
         fr_q       <= s_q[0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      good_d  = good_q;
      word_d  = word_q;
      to_d    = beat_q ? '0 : (to_q == TW'(TIMEOUT_CYC) ? to_q : to_q + 1'b1);
      data_d  = data_q;
      ovr_d   = ovr_q;
      dv_d    = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      if (beat_q) begin
         if (state_q == HUNT) begin
            if (fr_q) begin
               word_d  = {word_q[WORD_W-2*LANES-1:0], nib_q};
               cnt_d   = BW'(1);
               good_d  = '0;
               state_d = SYNC;
            end
         end else if (cnt_q == '0) begin
            if (fr_q) begin
               word_d = {word_q[WORD_W-2*LANES-1:0], nib_q};
               cnt_d  = BW'(1);
               if (state_q == SYNC) begin
                  good_d = good_q + 4'd1;
                  if ({1'b0, good_q} + 5'd1 >= 5'(LOCK_FRAMES)) state_d = LOCKED;
               end
            end else begin
               ferr_d  = 1'b1;
               state_d = HUNT;
            end
         end else if (fr_q) begin
            // Early frame marker restarts the frame on this beat.
            ferr_d  = 1'b1;
            word_d  = {word_q[WORD_W-2*LANES-1:0], nib_q};
            cnt_d   = BW'(1);
            good_d  = '0;
            state_d = SYNC;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q != BW'(BEATS - 1)) word_d = {word_q[WORD_W-2*LANES-1:0], nib_q};
            else if (state_q == LOCKED) begin
               perr_d = par_bad;
               dv_d   = !par_bad;
               data_d = par_bad ? data_q : {word_q, nib_q[LANES-1:2]};
               ovr_d  = par_bad ? ovr_q : nib_q[1];
            end
         end
      end else if (state_q != HUNT && to_q >= TW'(TIMEOUT_CYC - 1)) begin
         state_d = HUNT;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= HUNT;
         cnt_q   <= '0;
         good_q  <= '0;
         word_q  <= '0;
         to_q    <= '0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
         dv_q    <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         good_q  <= good_d;
         word_q  <= word_d;
         to_q    <= to_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
         dv_q    <= dv_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
      end
   end

   assign data_out   = data_q;
   assign ovr_out    = ovr_q;
   assign data_valid = dv_q;
   assign locked     = state_q == LOCKED;
   assign frame_err  = ferr_q;
   assign parity_err = perr_q;
endmodule

// File: tb/tb_qdr_lvds_rx.sv
// tb_qdr_lvds_rx: directed scenarios for qdr_lvds_rx with default parameters.
module tb_qdr_lvds_rx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  da = 4'h0;
   logic        daclk = 1'b0;
   logic        daframe = 1'b0;
   logic [13:0] data_out;
   logic        ovr_out, data_valid, locked, frame_err, parity_err;
   int          passed = 0;
   int          total = 0;
   int          dv_cnt = 0;
   int          fe_cnt = 0;
   int          pe_cnt = 0;
   int          dv0, fe0, pe0;

   qdr_lvds_rx dut (
      .clk        (clk),
      .reset      (rst_n),
      .DA         (da),
      .DACLK      (daclk),
      .DAFRAME    (daframe),
      .data_out   (data_out),
      .ovr_out    (ovr_out),
      .data_valid (data_valid),
      .locked     (locked),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_valid) dv_cnt <= dv_cnt + 1;
      if (frame_err)  fe_cnt <= fe_cnt + 1;
      if (parity_err) pe_cnt <= pe_cnt + 1;
   end

   task automatic send_beat(input logic [3:0] n, input logic f, input int g);
      da = n;
      daframe = f;
      daclk = ~daclk;
      repeat (g) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [15:0] w);
      for (int k = 0; k < 4; k++) send_beat(w[15-4*k -: 4], k == 0, 3);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (data_out !== 14'h0) $display("FAIL reset data_out: got %h want 0", data_out); else passed++;
      total++; if (ovr_out !== 1'b0) $display("FAIL reset ovr_out: got %b want 0", ovr_out); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL reset data_valid: got %b want 0", data_valid); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL reset locked: got %b want 0", locked); else passed++;
      total++; if (frame_err !== 1'b0) $display("FAIL reset frame_err: got %b want 0", frame_err); else passed++;
      total++; if (parity_err !== 1'b0) $display("FAIL reset parity_err: got %b want 0", parity_err); else passed++;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_lock;
      dv0 = dv_cnt;
      send_frame(16'h7FFD);
      total++; if (locked !== 1'b0) $display("FAIL lock after f1: got %b want 0", locked); else passed++;
      send_frame(16'h7FFD);
      total++; if (locked !== 1'b0) $display("FAIL lock after f2: got %b want 0", locked); else passed++;
      total++; if (dv_cnt - dv0 !== 0) $display("FAIL lock no dv in sync: got %0d want 0", dv_cnt - dv0); else passed++;
      send_frame(16'h7FFD);
      total++; if (locked !== 1'b1) $display("FAIL lock after f3: got %b want 1", locked); else passed++;
      total++; if (dv_cnt - dv0 !== 1) $display("FAIL lock dv count: got %0d want 1", dv_cnt - dv0); else passed++;
      total++; if (data_out !== 14'h1FFF) $display("FAIL lock data_out: got %h want 1fff", data_out); else passed++;
      total++; if (ovr_out !== 1'b0) $display("FAIL lock ovr_out: got %b want 0", ovr_out); else passed++;
   endtask

   task automatic test_latency;
      send_beat(4'h8, 1'b1, 3);
      send_beat(4'h0, 1'b0, 3);
      send_beat(4'h0, 1'b0, 3);
      send_beat(4'h2, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1;
      total++; if (data_valid !== 1'b0) $display("FAIL latency early dv: got %b want 0", data_valid); else passed++;
      @(posedge clk);
      #1;
      total++; if (data_valid !== 1'b1) $display("FAIL latency dv: got %b want 1", data_valid); else passed++;
      total++; if (data_out !== 14'h2000) $display("FAIL latency data_out: got %h want 2000", data_out); else passed++;
      total++; if (ovr_out !== 1'b1) $display("FAIL latency ovr_out: got %b want 1", ovr_out); else passed++;
      @(posedge clk);
      #1;
      total++; if (data_valid !== 1'b0) $display("FAIL latency dv width: got %b want 0", data_valid); else passed++;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_frame_err;
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_beat(4'h7, 1'b1, 3);
      send_beat(4'hF, 1'b0, 3);
      send_beat(4'h7, 1'b1, 5);
      total++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr pulse: got %0d want 1", fe_cnt - fe0); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL ferr locked: got %b want 0", locked); else passed++;
      send_beat(4'hF, 1'b0, 3);
      send_beat(4'hF, 1'b0, 3);
      send_beat(4'hD, 1'b0, 5);
      total++; if (dv_cnt - dv0 !== 0) $display("FAIL ferr no dv: got %0d want 0", dv_cnt - dv0); else passed++;
      send_frame(16'h7FFD);
      total++; if (locked !== 1'b0) $display("FAIL ferr relock early: got %b want 0", locked); else passed++;
      send_frame(16'h8002);
      total++; if (locked !== 1'b1) $display("FAIL ferr relock: got %b want 1", locked); else passed++;
      total++; if (dv_cnt - dv0 !== 1) $display("FAIL ferr relock dv: got %0d want 1", dv_cnt - dv0); else passed++;
      total++; if (data_out !== 14'h2000) $display("FAIL ferr relock data: got %h want 2000", data_out); else passed++;
      total++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr single: got %0d want 1", fe_cnt - fe0); else passed++;
   endtask

   task automatic test_timeout;
      fe0 = fe_cnt;
      repeat (40) @(posedge clk);
      #1;
      total++; if (locked !== 1'b1) $display("FAIL timeout early drop: got %b want 1", locked); else passed++;
      repeat (30) @(posedge clk);
      #1;
      total++; if (locked !== 1'b0) $display("FAIL timeout locked: got %b want 0", locked); else passed++;
      total++; if (fe_cnt - fe0 !== 0) $display("FAIL timeout ferr: got %0d want 0", fe_cnt - fe0); else passed++;
      total++; if (data_out !== 14'h2000) $display("FAIL timeout data hold: got %h want 2000", data_out); else passed++;
      total++; if (ovr_out !== 1'b1) $display("FAIL timeout ovr hold: got %b want 1", ovr_out); else passed++;
   endtask

   task automatic test_reset_mid;
      repeat (3) send_frame(16'h7FFD);
      total++; if (locked !== 1'b1) $display("FAIL rstmid prelock: got %b want 1", locked); else passed++;
      total++; if (data_out !== 14'h1FFF) $display("FAIL rstmid predata: got %h want 1fff", data_out); else passed++;
      send_beat(4'h7, 1'b1, 3);
      send_beat(4'hF, 1'b0, 3);
      send_beat(4'hF, 1'b0, 2);
      rst_n = 1'b0;
      #1;
      total++; if (data_out !== 14'h0) $display("FAIL rstmid data_out: got %h want 0", data_out); else passed++;
      total++; if (ovr_out !== 1'b0) $display("FAIL rstmid ovr_out: got %b want 0", ovr_out); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL rstmid locked: got %b want 0", locked); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL rstmid data_valid: got %b want 0", data_valid); else passed++;
      total++; if (frame_err !== 1'b0) $display("FAIL rstmid frame_err: got %b want 0", frame_err); else passed++;
      total++; if (parity_err !== 1'b0) $display("FAIL rstmid parity_err: got %b want 0", parity_err); else passed++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      dv0 = dv_cnt;
      send_frame(16'h8002);
      send_frame(16'h8002);
      total++; if (locked !== 1'b0) $display("FAIL rstmid relock early: got %b want 0", locked); else passed++;
      send_frame(16'h8002);
      total++; if (locked !== 1'b1) $display("FAIL rstmid relock: got %b want 1", locked); else passed++;
      total++; if (dv_cnt - dv0 !== 1) $display("FAIL rstmid dv: got %0d want 1", dv_cnt - dv0); else passed++;
      total++; if (data_out !== 14'h2000) $display("FAIL rstmid data: got %h want 2000", data_out); else passed++;
   endtask

   task automatic test_parity;
      dv0 = dv_cnt;
      pe0 = pe_cnt;
      send_frame(16'h7FFC);
`ifdef QDR_LVDS_RX_PARITY_CHECK_EN
      total++; if (pe_cnt - pe0 !== 1) $display("FAIL parity perr: got %0d want 1", pe_cnt - pe0); else passed++;
      total++; if (dv_cnt - dv0 !== 0) $display("FAIL parity dv: got %0d want 0", dv_cnt - dv0); else passed++;
      total++; if (data_out !== 14'h2000) $display("FAIL parity data hold: got %h want 2000", data_out); else passed++;
      total++; if (ovr_out !== 1'b1) $display("FAIL parity ovr hold: got %b want 1", ovr_out); else passed++;
`else
      total++; if (pe_cnt - pe0 !== 0) $display("FAIL parity perr: got %0d want 0", pe_cnt - pe0); else passed++;
      total++; if (dv_cnt - dv0 !== 1) $display("FAIL parity dv: got %0d want 1", dv_cnt - dv0); else passed++;
      total++; if (data_out !== 14'h1FFF) $display("FAIL parity data: got %h want 1fff", data_out); else passed++;
      total++; if (ovr_out !== 1'b0) $display("FAIL parity ovr: got %b want 0", ovr_out); else passed++;
`endif
      total++; if (locked !== 1'b1) $display("FAIL parity locked: got %b want 1", locked); else passed++;
   endtask

   initial begin
      test_reset;
      test_lock;
      test_latency;
      test_frame_err;
      test_timeout;
      test_reset_mid;
      test_parity;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
